// File: rtl/ushift_reg_pkg.sv
// Shared definitions for the universal shift register: operation codes and mode type.
package ushift_reg_pkg;

    typedef enum logic [2:0] {
        MD_HOLD = 3'b000,
        MD_LOAD = 3'b001,
        MD_SHL  = 3'b010,
        MD_SHR  = 3'b011,
        MD_ROL  = 3'b100,
        MD_ROR  = 3'b101,
        MD_ASR  = 3'b110,
        MD_CLR  = 3'b111
    } mode_t;

endpackage

// File: rtl/ushift_reg_dff_sr.sv
// One-bit positive-edge storage cell with synchronous active-high reset and enable.
module dff_sr (
    input  logic CK,
    input  logic RST,
    input  logic EN,
    input  logic D,
    output logic Q
);

    always_ff @(posedge CK) begin
        if (RST) begin
            Q <= 1'b0;
        end else if (EN) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/ushift_reg.sv
// Parametrised universal shift register: WIDTH storage cells fed by a next-state mux,
// plus a saturating count of shifts/rotates since the last load, clear or reset.
module ushift_reg
    import ushift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI_LSB,
    input  logic             SI_MSB,
    output logic [WIDTH-1:0] Q,
    output logic             SO_MSB,
    output logic             SO_LSB,
    output logic [CW-1:0]    CNT,
    output logic             FULL
);

    mode_t            w_mode;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next;
    logic             w_full;
    logic [CW-1:0]    r_cnt;

    assign w_mode = mode_t'(MODE);
    assign w_full = (r_cnt == CW'(WIDTH));

    always_comb begin
        w_next = w_q;
        case (w_mode)
            MD_HOLD: w_next = w_q;
            MD_LOAD: w_next = D;
            MD_SHL:  w_next = {w_q[WIDTH-2:0], SI_LSB};
            MD_SHR:  w_next = {SI_MSB, w_q[WIDTH-1:1]};
            MD_ROL:  w_next = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
            MD_ROR:  w_next = {w_q[0], w_q[WIDTH-1:1]};
            MD_ASR:  w_next = {w_q[WIDTH-1], w_q[WIDTH-1:1]};
            MD_CLR:  w_next = '0;
            default: w_next = w_q;
        endcase
    end

    // Cells share EN; HOLD is expressed by the mux feeding back the current bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_sr u_cell (
            .CK  (CK),
            .RST (RST),
            .EN  (EN),
            .D   (w_next[i]),
            .Q   (w_q[i])
        );
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (EN) begin
            case (w_mode)
                MD_LOAD, MD_CLR: r_cnt <= '0;
                MD_SHL, MD_SHR, MD_ROL, MD_ROR, MD_ASR: begin
                    if (!w_full) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign Q      = w_q;
    assign SO_MSB = w_q[WIDTH-1];
    assign SO_LSB = w_q[0];
    assign CNT    = r_cnt;
    assign FULL   = w_full;

endmodule

// File: tb/tb_ushift_reg.sv
// Self-checking bench for ushift_reg: directed vector table, a WIDTH=2 corner case,
// and randomized operations checked against an arithmetic reference model.
module tb_ushift_reg;

    logic       CK;
    logic       RST, EN, SI_LSB, SI_MSB;
    logic [2:0] MODE;
    logic [7:0] D, Q;
    logic       SO_MSB, SO_LSB, FULL;
    logic [3:0] CNT;

    logic       RST2, EN2, SI_LSB2, SI_MSB2;
    logic [2:0] MODE2;
    logic [1:0] D2, Q2;
    logic       SO_MSB2, SO_LSB2, FULL2;
    logic [1:0] CNT2;

    int n_cmp = 0;
    int n_bad = 0;

    ushift_reg #(.WIDTH(8)) dut (
        .CK(CK), .RST(RST), .EN(EN), .MODE(MODE), .D(D),
        .SI_LSB(SI_LSB), .SI_MSB(SI_MSB), .Q(Q), .SO_MSB(SO_MSB),
        .SO_LSB(SO_LSB), .CNT(CNT), .FULL(FULL)
    );

    ushift_reg #(.WIDTH(2)) dut2 (
        .CK(CK), .RST(RST2), .EN(EN2), .MODE(MODE2), .D(D2),
        .SI_LSB(SI_LSB2), .SI_MSB(SI_MSB2), .Q(Q2), .SO_MSB(SO_MSB2),
        .SO_LSB(SO_LSB2), .CNT(CNT2), .FULL(FULL2)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sil;
        logic       sim;
        logic       pre_chk;
        logic       pre_msb;
        logic [7:0] q;
        logic [3:0] cnt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic rst, logic en, logic [2:0] mode, logic [7:0] d,
                                logic sil, logic sim, logic pre_chk, logic pre_msb,
                                logic [7:0] q, logic [3:0] cnt);
        vec_t v;
        v.rst = rst; v.en = en; v.mode = mode; v.d = d; v.sil = sil; v.sim = sim;
        v.pre_chk = pre_chk; v.pre_msb = pre_msb; v.q = q; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic [2:0] mode,
                         input logic [7:0] d, input logic sil, input logic sim);
        RST = rst; EN = en; MODE = mode; D = d; SI_LSB = sil; SI_MSB = sim;
    endtask

    task automatic check_all(input string tag, input logic [7:0] eq, input int ec);
        chk({tag, ".Q"}, 64'(Q), 64'(eq));
        chk({tag, ".CNT"}, 64'(CNT), 64'(ec));
        chk({tag, ".FULL"}, 64'(FULL), 64'(ec == 8));
        chk({tag, ".SO_MSB"}, 64'(SO_MSB), 64'(eq[7]));
        chk({tag, ".SO_LSB"}, 64'(SO_LSB), 64'(eq[0]));
    endtask

    // Reference model: plain integer arithmetic on the register value.
    int mq;
    int mc;

    task automatic model_step(input logic rst, input logic en, input logic [2:0] mode,
                              input logic [7:0] d, input logic sil, input logic sim);
        if (rst) begin
            mq = 0; mc = 0;
        end else if (en) begin
            case (mode)
                3'd1: begin mq = int'(d); mc = 0; end
                3'd2: mq = (mq * 2 + int'(sil)) % 256;
                3'd3: mq = mq / 2 + int'(sim) * 128;
                3'd4: mq = (mq * 2) % 256 + mq / 128;
                3'd5: mq = mq / 2 + (mq % 2) * 128;
                3'd6: mq = mq / 2 + ((mq >= 128) ? 128 : 0);
                3'd7: begin mq = 0; mc = 0; end
                default: ;
            endcase
            if (mode >= 3'd2 && mode <= 3'd6) mc = (mc < 8) ? mc + 1 : 8;
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        RST2 = 1'b1; EN2 = 1'b0; MODE2 = 3'd0; D2 = 2'b00; SI_LSB2 = 1'b0; SI_MSB2 = 1'b0;

        // rst en mode d sil sim pre_chk pre_msb -> q cnt
        vt.push_back(mk(1, 0, 3'd0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
        vt.push_back(mk(0, 1, 3'd1, 8'hA5, 0, 0, 0, 0, 8'hA5, 0));
        vt.push_back(mk(0, 1, 3'd2, 8'h00, 1, 0, 1, 1, 8'h4B, 1));
        vt.push_back(mk(0, 1, 3'd2, 8'h00, 1, 0, 1, 0, 8'h97, 2));
        vt.push_back(mk(0, 1, 3'd2, 8'h00, 1, 0, 1, 1, 8'h2F, 3));
        vt.push_back(mk(0, 1, 3'd0, 8'hFF, 1, 1, 0, 0, 8'h2F, 3));
        vt.push_back(mk(0, 1, 3'd1, 8'h81, 0, 0, 0, 0, 8'h81, 0));
        vt.push_back(mk(0, 1, 3'd5, 8'h00, 1, 1, 0, 0, 8'hC0, 1));
        vt.push_back(mk(0, 1, 3'd5, 8'h00, 0, 1, 0, 0, 8'h60, 2));
        vt.push_back(mk(0, 1, 3'd5, 8'h00, 1, 0, 0, 0, 8'h30, 3));
        vt.push_back(mk(0, 1, 3'd5, 8'h00, 0, 0, 0, 0, 8'h18, 4));
        vt.push_back(mk(0, 1, 3'd5, 8'h00, 0, 0, 0, 0, 8'h0C, 5));
        vt.push_back(mk(0, 1, 3'd5, 8'h00, 0, 0, 0, 0, 8'h06, 6));
        vt.push_back(mk(0, 1, 3'd5, 8'h00, 0, 0, 0, 0, 8'h03, 7));
        vt.push_back(mk(0, 1, 3'd5, 8'h00, 0, 0, 0, 0, 8'h81, 8));
        vt.push_back(mk(0, 1, 3'd5, 8'h00, 0, 0, 0, 0, 8'hC0, 8));
        vt.push_back(mk(0, 1, 3'd5, 8'h00, 0, 0, 0, 0, 8'h60, 8));
        vt.push_back(mk(0, 1, 3'd1, 8'h90, 0, 0, 0, 0, 8'h90, 0));
        vt.push_back(mk(0, 1, 3'd6, 8'h00, 0, 0, 0, 0, 8'hC8, 1));
        vt.push_back(mk(0, 1, 3'd6, 8'h00, 0, 0, 0, 0, 8'hE4, 2));
        vt.push_back(mk(0, 1, 3'd1, 8'h90, 0, 0, 0, 0, 8'h90, 0));
        vt.push_back(mk(0, 1, 3'd3, 8'h00, 1, 0, 0, 0, 8'h48, 1));
        vt.push_back(mk(0, 1, 3'd3, 8'h00, 1, 0, 0, 0, 8'h24, 2));
        vt.push_back(mk(0, 1, 3'd1, 8'h1E, 0, 0, 0, 0, 8'h1E, 0));
        vt.push_back(mk(0, 1, 3'd2, 8'h00, 0, 0, 0, 0, 8'h3C, 1));
        for (int i = 0; i < 4; i++) vt.push_back(mk(0, 0, 3'd2, 8'hFF, 1, 1, 0, 0, 8'h3C, 1));
        vt.push_back(mk(0, 1, 3'd7, 8'hFF, 0, 0, 0, 0, 8'h00, 0));
        vt.push_back(mk(0, 1, 3'd1, 8'h01, 0, 0, 0, 0, 8'h01, 0));
        vt.push_back(mk(0, 1, 3'd2, 8'h00, 0, 0, 0, 0, 8'h02, 1));
        vt.push_back(mk(0, 1, 3'd2, 8'h00, 0, 0, 0, 0, 8'h04, 2));
        vt.push_back(mk(0, 1, 3'd2, 8'h00, 0, 0, 0, 0, 8'h08, 3));
        vt.push_back(mk(0, 1, 3'd2, 8'h00, 0, 0, 0, 0, 8'h10, 4));
        vt.push_back(mk(0, 1, 3'd2, 8'h00, 0, 0, 0, 0, 8'h20, 5));
        vt.push_back(mk(1, 1, 3'd1, 8'hFF, 1, 1, 0, 0, 8'h00, 0));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].en, vt[i].mode, vt[i].d, vt[i].sil, vt[i].sim);
            #1;
            if (vt[i].pre_chk) chk($sformatf("vec%0d.pre_SO_MSB", i), 64'(SO_MSB), 64'(vt[i].pre_msb));
            @(posedge CK); #1;
            check_all($sformatf("vec%0d", i), vt[i].q, int'(vt[i].cnt));
        end

        // WIDTH=2 instance: rotate, saturate at 2, keep rotating while saturated.
        RST2 = 1'b0; EN2 = 1'b1; MODE2 = 3'd1; D2 = 2'b10;
        @(posedge CK); #1;
        chk("w2.load.Q", 64'(Q2), 64'(2'b10));
        chk("w2.load.CNT", 64'(CNT2), 64'd0);
        MODE2 = 3'd4; SI_LSB2 = 1'b1; SI_MSB2 = 1'b1;
        @(posedge CK); #1;
        chk("w2.rol1.Q", 64'(Q2), 64'(2'b01));
        chk("w2.rol1.CNT", 64'(CNT2), 64'd1);
        chk("w2.rol1.FULL", 64'(FULL2), 64'd0);
        @(posedge CK); #1;
        chk("w2.rol2.Q", 64'(Q2), 64'(2'b10));
        chk("w2.rol2.FULL", 64'(FULL2), 64'd1);
        @(posedge CK); #1;
        chk("w2.rol3.Q", 64'(Q2), 64'(2'b01));
        chk("w2.rol3.CNT", 64'(CNT2), 64'd2);
        chk("w2.rol3.SO_LSB", 64'(SO_LSB2), 64'd1);

        // Randomized phase against the arithmetic model.
        mq = 0; mc = 0;
        for (int i = 0; i < 400; i++) begin
            logic       r_rst, r_en, r_sil, r_sim;
            logic [2:0] r_mode;
            logic [7:0] r_d;
            r_rst  = ($urandom_range(0, 19) == 0);
            r_en   = ($urandom_range(0, 7) != 0);
            r_mode = 3'($urandom_range(0, 7));
            if (r_mode == 3'd1 && $urandom_range(0, 1) == 1) r_mode = 3'($urandom_range(2, 6));
            r_d    = 8'($urandom);
            r_sil  = 1'($urandom);
            r_sim  = 1'($urandom);
            if (i == 0) r_rst = 1'b1;
            drive(r_rst, r_en, r_mode, r_d, r_sil, r_sim);
            model_step(r_rst, r_en, r_mode, r_d, r_sil, r_sim);
            @(posedge CK); #1;
            check_all($sformatf("rnd%0d", i), 8'(mq), mc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
